adder_nbits_seq: RTL and testbench

//  Parametrised multi-cycle adder and successor of the fixed 8-bit combinational adder.
//  - Latches two WIDTH-bit operands and a 1-bit carry on a start pulse.
//  - Adds them CHUNK bits per clock, LSB slice first, through a registered ripple carry.
//  - Reports sum, carry-out and signed overflow with a one-cycle done pulse.
//  - Sits beside datapath blocks that trade latency for a narrow adder.

---
 rtl/adder_nbits_seq.sv | 164 ++++++++++++++++
 tb/tb_adder_nbits_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adder_nbits_seq.sv
// adder_nbits_seq: multi-cycle WIDTH-bit adder that processes CHUNK bits per clock.
// The operands and carry are latched on start. Slices are added LSB first
// through a registered ripple carry. Sum, carry-out and signed overflow are
// published together with a one-cycle done pulse.
// Optional feature: define ADDER_SEQ_SUB_EN to add the `sub` port, which
// selects a - b (computed as a + ~b + 1).

// One CHUNK-wide slice of the ripple adder.
module adder_nbits_seq_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  // Full-width add; the extra top bit is the slice carry.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  end
endmodule

module adder_nbits_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  // WIDTH must be a multiple of CHUNK.
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Latched request. b holds the effective second operand, already inverted
  // when subtracting, so both the slice adder and the overflow check use it directly.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] part_q;     // shadow sum, assembled slice by slice
  logic [WIDTH-1:0] part_nxt;
  logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
  logic             sl_co;
  logic             accept, last;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Select the effective operand and carry that are latched at start.
  always_comb begin
    b_eff   = b;
    cin_eff = carry_in;
`ifdef ADDER_SEQ_SUB_EN
    if (sub) begin
      b_eff   = ~b;
      cin_eff = 1'b1;
    end
`endif
  end

  // Pick the slice addressed by idx. Only one CHUNK-wide adder exists.
  always_comb begin
    sl_a = op_q.a[idx_q*CHUNK +: CHUNK];
    sl_b = op_q.b[idx_q*CHUNK +: CHUNK];
  end

  adder_nbits_seq_slice #(.W(CHUNK)) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_sum),
    .co (sl_co)
  );

  // Merge the current slice result into the shadow sum.
  always_comb begin
    part_nxt = part_q;
    part_nxt[idx_q*CHUNK +: CHUNK] = sl_sum;
  end

  // Hold the FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Compute the next state. Start is sampled only when idle.
  // RUN ends on the edge that writes the top slice.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the request, ripple through the slices, and publish the results on the final slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      part_q    <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        op_q.a  <= a;
        op_q.b  <= b_eff;
        carry_q <= cin_eff;
        idx_q   <= '0;
      end else if (state == RUN) begin
        part_q  <= part_nxt;
        carry_q <= sl_co;
        idx_q   <= last ? '0 : idx_q + 1'b1;
        if (last) begin
          sum       <= part_nxt;
          carry_out <= sl_co;
          overflow  <= (op_q.a[WIDTH-1] == op_q.b[WIDTH-1]) &&
                       (sl_sum[CHUNK-1] != op_q.a[WIDTH-1]);
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_adder_nbits_seq.sv
// Directed bench for adder_nbits_seq. The main instance is 8-bit with 4-bit
// slices. A second 16-bit instance covers the four-slice case.
module tb_adder_nbits_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a_i = '0, b_i = '0;
  logic        cin_i = 1'b0;
  logic        sub_i = 1'b0;
  logic        busy, done, cout, ovf;
  logic [7:0]  sum;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_nbits_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .carry_in(cin_i),
`ifdef ADDER_SEQ_SUB_EN
    .sub(sub_i),
`endif
    .busy(busy), .done(done), .sum(sum), .carry_out(cout), .overflow(ovf)
  );

  adder_nbits_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .carry_in(1'b0),
`ifdef ADDER_SEQ_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(cout16), .overflow(ovf16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full 8-bit operation. It checks latency and result stability, and it
  // scrambles the inputs after the accepting edge.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] prev,
                        input logic [7:0] es, input logic ec, input logic eo);
    a_i = a; b_i = b; cin_i = cin; start = 1'b1;
    tick();
    start = 1'b0; a_i = ~a; b_i = ~b; cin_i = ~cin;
    check({tag, ".busy0"}, busy, 1);
    check({tag, ".done0"}, done, 0);
    check({tag, ".hold0"}, sum, prev);
    tick();
    check({tag, ".busy1"}, busy, 1);
    check({tag, ".hold1"}, sum, prev);
    tick();
    check({tag, ".busy2"}, busy, 0);
    check({tag, ".done"}, done, 1);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".ovf"}, ovf, eo);
    tick();
    check({tag, ".done_end"}, done, 0);
    check({tag, ".sum_held"}, sum, es);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.sum", sum, 0);
    check("rst.cout", cout, 0);
    check("rst.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic add, a carry across the slice boundary, and signed overflow cases
    run_op("t1", 8'h01, 8'h02, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0);
    run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0);
    run_op("t3a", 8'h80, 8'h80, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1);
    run_op("t3b", 8'h7F, 8'h01, 1'b0, 8'h01, 8'h80, 1'b0, 1'b1);

    // A start while busy is ignored
    a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0; start = 1'b1;
    tick();
    a_i = 8'h55; b_i = 8'h55; cin_i = 1'b1;  // start still high while busy
    tick();
    start = 1'b0;
    check("t4.busy", busy, 1);
    tick();
    check("t4.done", done, 1);
    check("t4.sum", sum, 8'h30);
    tick();
    check("t4.no_second_done", done, 0);
    check("t4.idle", busy, 0);
    tick();
    check("t4.still_no_done", done, 0);

    // Reset in the middle of a run
    a_i = 8'h0F; b_i = 8'h01; cin_i = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5.busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t5.busy", busy, 0);
    check("t5.done", done, 0);
    check("t5.sum", sum, 0);
    check("t5.cout", cout, 0);
    check("t5.ovf", ovf, 0);
    #2 rst = 1'b0;
    tick();
    check("t5.no_done_a", done, 0);
    tick();
    check("t5.no_done_b", done, 0);
    run_op("t5.after", 8'h22, 8'h11, 1'b1, 8'h00, 8'h34, 1'b0, 1'b0);

    // With start held high, the next operation is accepted in the done cycle.
    a_i = 8'h01; b_i = 8'h01; cin_i = 1'b0; start = 1'b1;
    tick();                       // accept at edge k
    a_i = 8'h02; b_i = 8'h03;     // operands for the second operation
    tick();
    tick();                       // after edge k+2: done cycle
    check("t6.done1", done, 1);
    check("t6.sum1", sum, 8'h02);
    check("t6.busy_in_done", busy, 0);
    tick();                       // accept at edge k+3
    check("t6.busy2", busy, 1);
    check("t6.done_gap", done, 0);
    start = 1'b0;
    tick();
    check("t6.hold2", sum, 8'h02);
    tick();                       // after edge k+5
    check("t6.done2", done, 1);
    check("t6.sum2", sum, 8'h05);

`ifdef ADDER_SEQ_SUB_EN
    tick();
    sub_i = 1'b1;
    run_op("sub", 8'h05, 8'h07, 1'b0, 8'h05, 8'hFE, 1'b0, 1'b0);
    sub_i = 1'b0;
`endif

    // 16-bit instance: four busy cycles, with the carry rippling through every slice
    tick();
    a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1'b1;
    tick();
    start16 = 1'b0; a16 = '0; b16 = '0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w16.busy%0d", i), busy16, 1);
      check($sformatf("w16.nodone%0d", i), done16, 0);
      tick();
    end
    check("w16.busy_end", busy16, 0);
    check("w16.done", done16, 1);
    check("w16.sum", sum16, 16'h0000);
    check("w16.cout", cout16, 1);
    check("w16.ovf", ovf16, 0);
    tick();
    check("w16.done_end", done16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
